// File: rtl/uart_rx_ram_loader.sv
// UART 8N1 receiver that streams received characters into the 60x7 character RAM.
// Shares the 16x baud tick with the transmit path; provides write strobe and status flags.
module uart_rx_ram_loader #(
    parameter int         RAMAddressSize = 6,
    parameter int         RAMDepth       = 60,
    parameter logic [7:0] Terminator     = 8'h0D
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      en_16_x_baud,
    input  logic                      rx,
    input  logic                      Enable,
    input  logic                      ClearAddress,
    output logic [RAMAddressSize-1:0] RAMaddress,
    output logic [6:0]                RAMdata,
    output logic                      RAMwrite,
    output logic [7:0]                rx_data,
    output logic                      rx_valid,
    output logic                      FramingError,
    output logic                      BufferFull,
    output logic                      LineDone,
    output logic                      Receiving
);

    // state    | meaning
    // IDLE     | line idle, waiting for a falling edge
    // START    | start bit, validated at mid-bit
    // DATA     | eight data bits, LSB first, sampled at mid-bit
    // STOP     | stop bit, sampled at mid-bit
    // WAITHIGH | bad stop bit seen, wait for line to return high
    // WRITE    | one clock: publish byte, write RAM or flag line end
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAITHIGH,
        WRITE
    } state_t;

    localparam logic [RAMAddressSize-1:0] LAST_ADDR = RAMAddressSize'(RAMDepth - 1);

    state_t     state, state_nxt;
    logic       rx_meta, rx_sync;
    logic [3:0] tick_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic       shift_en;
    logic       load_data;
    logic       set_ferr;
    logic       is_term;

    assign is_term = (rx_data == Terminator);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            tick_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state) begin
                tick_cnt <= '0;
            end else if (en_16_x_baud) begin
                tick_cnt <= tick_cnt + 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        load_data = 1'b0;
        set_ferr  = 1'b0;
        rx_valid  = 1'b0;
        RAMwrite  = 1'b0;
        RAMdata   = '0;
        LineDone  = 1'b0;
        Receiving = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_sync) state_nxt = START;
            end
            START: begin
                Receiving = 1'b1;
                if (en_16_x_baud && tick_cnt == 4'd7) begin
                    state_nxt = rx_sync ? IDLE : DATA;
                end
            end
            DATA: begin
                Receiving = 1'b1;
                if (en_16_x_baud && tick_cnt == 4'd15) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                Receiving = 1'b1;
                if (en_16_x_baud && tick_cnt == 4'd15) begin
                    if (rx_sync) begin
                        state_nxt = WRITE;
                        load_data = 1'b1;
                    end else begin
                        state_nxt = WAITHIGH;
                        set_ferr  = 1'b1;
                    end
                end
            end
            WAITHIGH: begin
                if (rx_sync) state_nxt = IDLE;
            end
            WRITE: begin
                Receiving = 1'b1;
                rx_valid  = 1'b1;
                state_nxt = IDLE;
                if (is_term) begin
                    LineDone = 1'b1;
                end else if (Enable && !BufferFull) begin
                    RAMwrite = 1'b1;
                    RAMdata  = rx_data[6:0];
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
        end else begin
            if (state != DATA) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (shift_en) shift_reg <= {rx_sync, shift_reg[7:1]};
            if (load_data) rx_data <= shift_reg;
        end
    end

    // ClearAddress wins over the address update of a coinciding write
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            RAMaddress   <= '0;
            BufferFull   <= 1'b0;
            FramingError <= 1'b0;
        end else if (ClearAddress) begin
            RAMaddress   <= '0;
            BufferFull   <= 1'b0;
            FramingError <= 1'b0;
        end else begin
            if (set_ferr) FramingError <= 1'b1;
            if (LineDone) begin
                RAMaddress <= '0;
            end else if (RAMwrite) begin
                if (RAMaddress == LAST_ADDR) begin
                    BufferFull <= 1'b1;
                end else begin
                    RAMaddress <= RAMaddress + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/uart_rx_ram_loader.md
Name: uart_rx_ram_loader

Overview:
- UART 8N1 receiver that loads received ASCII characters into the 60x7-bit RAM, so host text can be written over the serial port instead of the switches.
- Counterpart to the SendChars/UART transmit path; shares the same en_16_x_baud tick.
- Outputs a RAM address, data and a write strobe for the top-level RAM mux, plus status for LEDs and the seven-segment display.

Parameters:
- RAMAddressSize, 6, width of RAM address and character count.
- RAMDepth, 60, number of RAM locations; legal addresses are 0..RAMDepth-1.
- Terminator, 8'h0D, line-end character; it is never stored.

Ports:
- clock  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- en_16_x_baud  input  1  one-clock tick at 16x the baud rate.
- rx  input  1  serial line, asynchronous, idles high.
- Enable  input  1  1 = store received characters into RAM.
- ClearAddress  input  1  synchronous one-clock pulse: clears address and flags.
- RAMaddress  output  RAMAddressSize  next write address.
- RAMdata  output  7  received character bits [6:0].
- RAMwrite  output  1  one-clock RAM write strobe.
- rx_data  output  8  last good received byte.
- rx_valid  output  1  one-clock pulse for each good frame.
- FramingError  output  1  sticky; set on a bad stop bit.
- BufferFull  output  1  sticky; set when location RAMDepth-1 has been written.
- LineDone  output  1  one-clock pulse when Terminator is received.
- Receiving  output  1  high while a frame is in progress.

Behaviour:
- Reset (reset=0, asynchronous) forces: state IDLE, all outputs 0, RAMaddress 0, sync flops 1.
- Input synchroniser: rx passes through 2 flip-flops; the FSM uses only the synchronised value.
- Tick counter: 4-bit, advances only on en_16_x_baud, cleared on each state change.
- IDLE: on a synchronised rx=0, go to START.
- START: after 8 ticks, sample rx.
  - rx=1: false start, return to IDLE with no flags set.
  - rx=0: go to DATA.
- DATA: every 16 ticks, shift in one bit, LSB first; after bit 7, go to STOP.
- STOP: after 16 ticks, sample rx.
  - rx=1: go to WRITE.
  - rx=0: set FramingError, discard the byte, go to WAITHIGH.
- WAITHIGH: stay until synchronised rx=1, then go to IDLE. This prevents a break condition from re-triggering a start.
- WRITE: lasts exactly one clock.
  - rx_valid=1 and rx_data is updated.
  - If the byte equals Terminator: LineDone=1, no write, RAMaddress returns to 0 on the next clock.
  - Else if Enable=1 and BufferFull=0: RAMwrite=1 with RAMdata=byte[6:0] and RAMaddress unchanged during the strobe. RAMaddress increments on the next clock; at RAMDepth-1 it holds its value and BufferFull is set instead.
  - Else: no write, address unchanged.
  - Next state is IDLE.
- Receiving = 1 in START, DATA, STOP and WRITE.
- Latency: rx_valid and RAMwrite assert 1 clock after the en tick that samples the stop bit.
- ClearAddress:
  - Sets RAMaddress=0 and clears BufferFull and FramingError.
  - Has priority over a coinciding WRITE-state address update: that write strobe still occurs at the old address, then the address becomes 0.
  - Does not disturb a frame in progress.
- Byte bit 7 is ignored for RAM storage; rx_data keeps all 8 bits.
- Enable changing mid-frame is sampled only in the WRITE state.

Test Plan:
- Reset low mid-frame while rx=0 → all outputs 0 immediately; after release with rx=1, stays in IDLE; next clean frame is received correctly.
- Enable=1, send 8'h41 then 8'h42 at 16 ticks/bit → RAMwrite at address 0 with data 7'h41, then at address 1 with data 7'h42; rx_valid pulses twice; RAMaddress ends at 2.
- rx low for 4 ticks then high → no rx_valid, Receiving drops; a following 8'h55 frame is received correctly.
- Frame 8'h33 with stop bit 0 → FramingError=1, no RAMwrite; WAITHIGH held until rx=1; next good frame writes; FramingError stays set until ClearAddress.
- 61 non-terminator characters with Enable=1 → 60 writes to addresses 0..59, BufferFull=1 after the 60th, 61st gives rx_valid only; ClearAddress → address 0, BufferFull=0.
- Send 8'h0D after 3 characters → LineDone pulse, no write, RAMaddress=0; Enable=0 then 8'h41 → rx_valid=1, rx_data=8'h41, no RAMwrite.
